axi_cpu_master: RTL and testbench

//  CPU-side AXI4 master bridge feeding the instruction/data memory slaves through the bus.

---
 rtl/axi_cpu_master.sv | 193 +++++++++++++++++++
 tb/tb_axi_cpu_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cpu_master.sv
// axi_cpu_master: CPU-side AXI4 master bridge. One CPU request becomes one single-beat
// AXI read (AR->R) or write (AW->W->B). The CPU is stalled until completion. Only one
// transaction is outstanding at a time.
// Optional feature macro: AXI_MASTER_ERR_EN adds a sticky error flag (err) with a clear
// input (err_clr), set by a non-OKAY RRESP/BRESP.

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

module axi_cpu_master #(
   parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = '0
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   // CPU side
   input  logic                    req,
   input  logic                    we,
   input  logic [31:0]             addr,
   input  logic [31:0]             wdata,
   input  logic [3:0]              wstrb,
   output logic                    stall,
   output logic [31:0]             rdata,
   output logic                    done,
`ifdef AXI_MASTER_ERR_EN
   output logic                    err,
   input  logic                    err_clr,
`endif
   // AXI read address channel
   output logic [`AXI_ID_BITS-1:0] ARID,
   output logic [31:0]             ARADDR,
   output logic [3:0]              ARLEN,
   output logic [2:0]              ARSIZE,
   output logic [1:0]              ARBURST,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   // AXI read data channel
   input  logic [`AXI_ID_BITS-1:0] RID,
   input  logic [31:0]             RDATA,
   input  logic [1:0]              RRESP,
   input  logic                    RLAST,
   input  logic                    RVALID,
   output logic                    RREADY,
   // AXI write address channel
   output logic [`AXI_ID_BITS-1:0] AWID,
   output logic [31:0]             AWADDR,
   output logic [3:0]              AWLEN,
   output logic [2:0]              AWSIZE,
   output logic [1:0]              AWBURST,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   // AXI write data channel
   output logic [31:0]             WDATA,
   output logic [3:0]              WSTRB,
   output logic                    WLAST,
   output logic                    WVALID,
   input  logic                    WREADY,
   // AXI write response channel
   input  logic [`AXI_ID_BITS-1:0] BID,
   input  logic [1:0]              BRESP,
   input  logic                    BVALID,
   output logic                    BREADY
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RADDR,
      ST_RDATA_W,
      ST_WADDR,
      ST_WDATA_W,
      ST_WRESP,
      ST_DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_wstrb;

   logic        accept;
   logic        rd_end;
   logic        wr_end;

   // Handshakes that end a transaction, shared by the FSM and the error flag.
   assign accept = (state == ST_IDLE) && req;
   assign rd_end = (state == ST_RDATA_W) && RVALID && RLAST;
   assign wr_end = (state == ST_WRESP) && BVALID;

   // Burst shape is fixed: single 32-bit INCR beat, last beat whenever data is presented.
   assign ARID    = MASTER_ID;
   assign AWID    = MASTER_ID;
   assign ARLEN   = 4'd0;
   assign AWLEN   = 4'd0;
   assign ARSIZE  = 3'b010;
   assign AWSIZE  = 3'b010;
   assign ARBURST = 2'b01;
   assign AWBURST = 2'b01;
   assign ARADDR  = lat_addr;
   assign AWADDR  = lat_addr;
   assign WDATA   = lat_wdata;
   assign WSTRB   = lat_wstrb;
   assign WLAST   = WVALID;

   // State register; reset drops any in-flight access.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state and channel control decode.
   always_comb begin
      state_nxt = state;
      ARVALID   = 1'b0;
      RREADY    = 1'b0;
      AWVALID   = 1'b0;
      WVALID    = 1'b0;
      BREADY    = 1'b0;
      done      = 1'b0;
      stall     = 1'b1;
      case (state)
         ST_IDLE: begin
            stall = req;
            if (req) state_nxt = we ? ST_WADDR : ST_RADDR;
         end
         ST_RADDR: begin
            ARVALID = 1'b1;
            if (ARREADY) state_nxt = ST_RDATA_W;
         end
         ST_RDATA_W: begin
            RREADY = 1'b1;
            if (rd_end) state_nxt = ST_DONE;
         end
         ST_WADDR: begin
            AWVALID = 1'b1;
            if (AWREADY) state_nxt = ST_WDATA_W;
         end
         ST_WDATA_W: begin
            WVALID = 1'b1;
            if (WREADY) state_nxt = ST_WRESP;
         end
         ST_WRESP: begin
            BREADY = 1'b1;
            if (wr_end) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            stall     = 1'b0;
            state_nxt = ST_IDLE;
         end
         default: begin
            stall     = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Request fields are captured only on acceptance, so they stay frozen while VALID is up.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
      end else if (accept) begin
         lat_addr  <= addr;
         lat_wdata <= wdata;
         lat_wstrb <= wstrb;
      end
   end

   // Read data capture; any accepted beat updates rdata, the last one completes.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn)                              rdata <= '0;
      else if ((state == ST_RDATA_W) && RVALID)  rdata <= RDATA;
   end

`ifdef AXI_MASTER_ERR_EN
   // Sticky error flag; a clear request takes priority over a new error.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn)                                               err <= 1'b0;
      else if (err_clr)                                           err <= 1'b0;
      else if ((rd_end && RRESP != 2'b00) || (wr_end && BRESP != 2'b00)) err <= 1'b1;
   end

   logic unused_ids;
   assign unused_ids = ^{RID, BID};
`else
   logic unused_resp;
   assign unused_resp = ^{RID, BID, RRESP, BRESP};
`endif

endmodule

// File: tb/tb_axi_cpu_master.sv
// Directed testbench for axi_cpu_master: reads, writes, backpressure, reset mid-write,
// back-to-back requests and (with AXI_MASTER_ERR_EN) the sticky error flag.

`timescale 1ns/1ps

module tb_axi_cpu_master;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  wstrb;
   logic        stall, done;
   logic [31:0] rdata;
`ifdef AXI_MASTER_ERR_EN
   logic        err, err_clr;
`endif
   logic [3:0]  ARID, AWID, RID, BID;
   logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
   logic [3:0]  ARLEN, AWLEN, WSTRB;
   logic [2:0]  ARSIZE, AWSIZE;
   logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

   int n_total = 0;
   int n_pass  = 0;

   axi_cpu_master #(.MASTER_ID(4'h0)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .stall(stall), .rdata(rdata), .done(done),
`ifdef AXI_MASTER_ERR_EN
      .err(err), .err_clr(err_clr),
`endif
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
   );

   always #5 ACLK = ~ACLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   initial begin
      ARESETn = 1'b0;
      req = 0; we = 0; addr = 0; wdata = 0; wstrb = 0;
`ifdef AXI_MASTER_ERR_EN
      err_clr = 0;
`endif
      ARREADY = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
      AWREADY = 0; WREADY = 0; BID = 0; BRESP = 0; BVALID = 0;

      // ---- reset state ----
      step(); step();
      check_val("rst_stall", stall, 0);
      check_val("rst_done", done, 0);
      check_val("rst_rdata", rdata, 0);
      check_val("rst_arvalid", ARVALID, 0);
      check_val("rst_awvalid", AWVALID, 0);
      check_val("rst_wvalid", WVALID, 0);
      check_val("rst_rready", RREADY, 0);
      check_val("rst_bready", BREADY, 0);
`ifdef AXI_MASTER_ERR_EN
      check_val("rst_err", err, 0);
`endif
      req = 1; #1;
      check_val("rst_stall_follows_req", stall, 1);
      req = 0; #1;
      ARESETn = 1'b1;
      step();

      // ---- read, zero-wait slave ----
      ARREADY = 1; RVALID = 1; RLAST = 1; RDATA = 32'hDEAD_BEEF;
      req = 1; we = 0; addr = 32'h0000_0010;
      #1 check_val("rd_idle_stall", stall, 1);
      step();
      req = 0;
      check_val("rd_arvalid", ARVALID, 1);
      check_val("rd_araddr", ARADDR, 32'h10);
      check_val("rd_arlen", ARLEN, 0);
      check_val("rd_arsize", ARSIZE, 3'b010);
      check_val("rd_arburst", ARBURST, 2'b01);
      check_val("rd_arid", ARID, 0);
      check_val("rd_done_c1", done, 0);
      step();
      check_val("rd_rready", RREADY, 1);
      check_val("rd_arvalid_off", ARVALID, 0);
      check_val("rd_done_c2", done, 0);
      step();
      check_val("rd_done_c3", done, 1);
      check_val("rd_rdata", rdata, 32'hDEAD_BEEF);
      check_val("rd_stall_done", stall, 0);
      step();
      check_val("rd_done_pulse", done, 0);
      ARREADY = 0; RVALID = 0; RLAST = 0;

      // ---- write, zero-wait slave ----
      AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 0;
      req = 1; we = 1; addr = 32'h0001_0004; wdata = 32'h1234_5678; wstrb = 4'b0011;
      step();
      req = 0;
      check_val("wr_awvalid", AWVALID, 1);
      check_val("wr_awaddr", AWADDR, 32'h0001_0004);
      check_val("wr_wvalid_in_waddr", WVALID, 0);
      check_val("wr_awsize", AWSIZE, 3'b010);
      step();
      check_val("wr_awvalid_off", AWVALID, 0);
      check_val("wr_wvalid", WVALID, 1);
      check_val("wr_wlast", WLAST, 1);
      check_val("wr_wstrb", WSTRB, 4'b0011);
      check_val("wr_wdata", WDATA, 32'h1234_5678);
      step();
      check_val("wr_bready", BREADY, 1);
      check_val("wr_wvalid_off", WVALID, 0);
      check_val("wr_done_c3", done, 0);
      step();
      check_val("wr_done_c4", done, 1);
      check_val("wr_stall_done", stall, 0);
      step();
      check_val("wr_done_pulse", done, 0);
      AWREADY = 0; WREADY = 0; BVALID = 0;

      // ---- read with backpressure ----
      req = 1; we = 0; addr = 32'h0000_0020;
      step();
      req = 0; addr = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         check_val("bp_arvalid_hold", ARVALID, 1);
         check_val("bp_araddr_hold", ARADDR, 32'h20);
         check_val("bp_stall_ar", stall, 1);
         step();
      end
      check_val("bp_arvalid_late", ARVALID, 1);
      ARREADY = 1;
      step();
      ARREADY = 0;
      for (int i = 0; i < 3; i++) begin
         check_val("bp_rready", RREADY, 1);
         check_val("bp_stall_r", stall, 1);
         check_val("bp_no_done", done, 0);
         step();
      end
      RVALID = 1; RLAST = 0; RDATA = 32'h1111_2222;
      step();
      check_val("bp_nolast_done", done, 0);
      check_val("bp_nolast_rdata", rdata, 32'h1111_2222);
      check_val("bp_nolast_rready", RREADY, 1);
      RLAST = 1; RDATA = 32'hCAFE_F00D;
      step();
      RVALID = 0; RLAST = 0;
      check_val("bp_done", done, 1);
      check_val("bp_rdata", rdata, 32'hCAFE_F00D);
      step();
      check_val("bp_single_pulse", done, 0);
      check_val("bp_idle_stall", stall, 0);

      // ---- reset in the middle of a write ----
      AWREADY = 1; WREADY = 0;
      req = 1; we = 1; addr = 32'h0000_0040; wdata = 32'hAAAA_5555; wstrb = 4'hF;
      step();
      req = 0;
      step();
      check_val("mr_wvalid_pre", WVALID, 1);
      #1 ARESETn = 1'b0;
      #1;
      check_val("mr_wvalid_async", WVALID, 0);
      check_val("mr_done", done, 0);
      check_val("mr_stall", stall, 0);
      check_val("mr_awaddr_clr", AWADDR, 0);
      check_val("mr_wstrb_clr", WSTRB, 0);
      step();
      check_val("mr_wvalid_held", WVALID, 0);
      ARESETn = 1'b1;
      AWREADY = 0;
      ARREADY = 1; RVALID = 1; RLAST = 1; RDATA = 32'h5555_AAAA;
      req = 1; we = 0; addr = 32'h0000_0050;
      step();
      req = 0;
      check_val("mr_rd_arvalid", ARVALID, 1);
      check_val("mr_rd_araddr", ARADDR, 32'h50);
      step(); step();
      check_val("mr_rd_done", done, 1);
      check_val("mr_rd_rdata", rdata, 32'h5555_AAAA);
      step();

      // ---- back-to-back reads with req held high ----
      RDATA = 32'h600D_0001;
      req = 1; we = 0; addr = 32'h0000_0060;
      step();
      check_val("bb_ar1", ARVALID, 1);
      addr = 32'h0000_0064;
      #1 check_val("bb_araddr1_frozen", ARADDR, 32'h60);
      step();
      step();
      check_val("bb_done1", done, 1);
      check_val("bb_rdata1", rdata, 32'h600D_0001);
      RDATA = 32'h600D_0002;
      step();
      check_val("bb_idle_arvalid", ARVALID, 0);
      check_val("bb_idle_stall", stall, 1);
      check_val("bb_idle_done", done, 0);
      step();
      req = 0;
      check_val("bb_ar2", ARVALID, 1);
      check_val("bb_araddr2", ARADDR, 32'h64);
      step(); step();
      check_val("bb_done2", done, 1);
      check_val("bb_rdata2", rdata, 32'h600D_0002);
      step();
      check_val("bb_after_done", done, 0);
      step();
      check_val("bb_no_dup_ar", ARVALID, 0);
      check_val("bb_no_dup_stall", stall, 0);
      ARREADY = 0; RVALID = 0; RLAST = 0;

`ifdef AXI_MASTER_ERR_EN
      // ---- sticky error flag ----
      AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b11;
      req = 1; we = 1; addr = 32'h0000_0070; wdata = 32'h0; wstrb = 4'hF;
      step();
      req = 0;
      step(); step();
      check_val("er_before_done", err, 0);
      step();
      check_val("er_wr_done", done, 1);
      check_val("er_set", err, 1);
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
      step();
      ARREADY = 1; RVALID = 1; RLAST = 1; RRESP = 0; RDATA = 32'h0BAD_0BAD;
      req = 1; we = 0; addr = 32'h0000_0074;
      step();
      req = 0;
      step(); step();
      check_val("er_rd_done", done, 1);
      check_val("er_sticky", err, 1);
      ARREADY = 0; RVALID = 0; RLAST = 0;
      step();
      err_clr = 1;
      step();
      err_clr = 0;
      check_val("er_cleared", err, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global time guard so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
